// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU function codes, HI/LO unit
// opcodes, mul/div FSM states and the EX/MEM pipeline register layout.
package mips_pkg;

    localparam int MD_CYCLES = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIVU  = 3'd2,
        MD_MFHI  = 3'd3,
        MD_MFLO  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic        syscall;
        logic        halt;
        logic        mem_to_reg;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic        pc_to_reg;
        logic [4:0]  rw;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] addr;
        logic [31:0] data;
    } exmem_t;

    // Any instruction that touches the HI/LO unit must wait while it is busy.
    function automatic logic md_uses_hilo(input logic [2:0] op);
        return (op == MD_MULTU) || (op == MD_DIVU) || (op == MD_MFHI) ||
               (op == MD_MFLO)  || (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit owning the HI and LO registers.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready; accepts start and MTHI/MTLO writes
//   RUN   | one shift-add (MULTU) or restoring step (DIVU) per cycle
//   DONE  | copies the accumulator into HI/LO, returns to IDLE
//
// Divide by zero needs no special case: every trial subtraction succeeds,
// so the quotient fills with ones and the remainder ends up equal to A.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int MD_CYCLES_P = MD_CYCLES
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] CNT_INIT = 6'(MD_CYCLES_P - 1);

    md_state_e   state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [32:0] mul_sum;
    logic [32:0] div_r;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [63:0] acc_step;

    // One iteration of the selected algorithm on the current accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_r    = {acc_q[63:32], acc_q[31]};
        div_ge   = (div_r >= {1'b0, opnd_q});
        div_rem  = div_ge ? (div_r - {1'b0, opnd_q}) : div_r;
        acc_step = is_div_q ? {div_rem[31:0], acc_q[30:0], div_ge}
                            : {mul_sum, acc_q[31:1]};
    end

    // Sequencer, iteration counter, accumulator and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= MDS_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (en) begin
            case (state_q)
                MDS_IDLE: begin
                    if (start) begin
                        is_div_q <= (op == MD_DIVU);
                        opnd_q   <= (op == MD_DIVU) ? b : a;
                        acc_q    <= {32'd0, (op == MD_DIVU) ? a : b};
                        cnt_q    <= CNT_INIT;
                        state_q  <= MDS_RUN;
                    end
                    if (mthi_we) hi_q <= wdata;
                    if (mtlo_we) lo_q <= wdata;
                end
                MDS_RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) state_q <= MDS_DONE;
                end
                MDS_DONE: begin
                    hi_q    <= acc_q[63:32];
                    lo_q    <= acc_q[31:0];
                    state_q <= MDS_IDLE;
                end
                default: state_q <= MDS_IDLE;
            endcase
        end
    end

    assign busy = (state_q != MDS_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, HI/LO result select, HI/LO hazard stall and
// the EX/MEM pipeline register feeding the MEM stage.
module ex_stage
    import mips_pkg::*;
#(
    parameter int MD_CYCLES_P = MD_CYCLES
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        NewHalt,
    input  logic [31:0] PC2,
    input  logic [31:0] IR2,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] Imm32,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUOp,
    input  logic [2:0]  MDOp,
    input  logic        SysCall2,
    input  logic        Halt2,
    input  logic        MemToReg2,
    input  logic        MemWrite2,
    input  logic        MemRead2,
    input  logic        RegWrite2,
    input  logic        PCtoReg2,
    input  logic [4:0]  RW2,
    output logic        SysCall3,
    output logic        Halt3,
    output logic        MemToReg3,
    output logic        MemWrite3,
    output logic        MemRead3,
    output logic        RegWrite3,
    output logic        PCtoReg3,
    output logic [31:0] Addr,
    output logic [31:0] Data,
    output logic [31:0] PC3,
    output logic [31:0] IR3,
    output logic [4:0]  RW3,
    output logic        Stall,
    output logic        MDBusy
);

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_busy;
    logic        md_idle_go;
    logic        md_start;
    logic        mthi_we;
    logic        mtlo_we;
    exmem_t      exmem_d;
    exmem_t      exmem_q;

    assign op2   = ALUSrc ? Imm32 : B;
    assign shamt = IR2[10:6];

    // Combinational ALU; shifts and LUI act on operand2.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            ALU_ADD:  alu_res = A + op2;
            ALU_SUB:  alu_res = A - op2;
            ALU_AND:  alu_res = A & op2;
            ALU_OR:   alu_res = A | op2;
            ALU_XOR:  alu_res = A ^ op2;
            ALU_NOR:  alu_res = ~(A | op2);
            ALU_SLT:  alu_res = {31'd0, $signed(A) < $signed(op2)};
            ALU_SLTU: alu_res = {31'd0, A < op2};
            ALU_SLL:  alu_res = op2 << shamt;
            ALU_SRL:  alu_res = op2 >> shamt;
            ALU_SRA:  alu_res = $signed(op2) >>> shamt;
            ALU_LUI:  alu_res = {op2[15:0], 16'h0000};
            default:  alu_res = '0;
        endcase
    end

    // HI/LO reads replace the ALU result.
    always_comb begin
        result = alu_res;
        if (MDOp == MD_MFHI)      result = hi;
        else if (MDOp == MD_MFLO) result = lo;
    end

    assign Stall      = NewHalt & md_uses_hilo(MDOp) & md_busy;
    assign md_idle_go = NewHalt & ~md_busy;
    assign md_start   = md_idle_go & ((MDOp == MD_MULTU) | (MDOp == MD_DIVU));
    assign mthi_we    = md_idle_go & (MDOp == MD_MTHI);
    assign mtlo_we    = md_idle_go & (MDOp == MD_MTLO);

    muldiv_unit #(
        .MD_CYCLES_P (MD_CYCLES_P)
    ) u_muldiv (
        .clk     (clk),
        .clear   (clear),
        .en      (NewHalt),
        .start   (md_start),
        .op      (MDOp),
        .a       (A),
        .b       (B),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (A),
        .busy    (md_busy),
        .hi      (hi),
        .lo      (lo)
    );

    // Next EX/MEM contents: hold when disabled, bubble when stalled.
    always_comb begin
        exmem_d = exmem_q;
        if (NewHalt) begin
            if (Stall) begin
                exmem_d = '0;
            end else begin
                exmem_d.syscall    = SysCall2;
                exmem_d.halt       = Halt2;
                exmem_d.mem_to_reg = MemToReg2;
                exmem_d.mem_write  = MemWrite2;
                exmem_d.mem_read   = MemRead2;
                exmem_d.reg_write  = RegWrite2;
                exmem_d.pc_to_reg  = PCtoReg2;
                exmem_d.rw         = RW2;
                exmem_d.pc         = PC2;
                exmem_d.ir         = IR2;
                exmem_d.addr       = result;
                exmem_d.data       = B;
            end
        end
    end

    // EX/MEM pipeline register with synchronous flush.
    always_ff @(posedge clk) begin
        if (clear) exmem_q <= '0;
        else       exmem_q <= exmem_d;
    end

    assign SysCall3  = exmem_q.syscall;
    assign Halt3     = exmem_q.halt;
    assign MemToReg3 = exmem_q.mem_to_reg;
    assign MemWrite3 = exmem_q.mem_write;
    assign MemRead3  = exmem_q.mem_read;
    assign RegWrite3 = exmem_q.reg_write;
    assign PCtoReg3  = exmem_q.pc_to_reg;
    assign RW3       = exmem_q.rw;
    assign PC3       = exmem_q.pc;
    assign IR3       = exmem_q.ir;
    assign Addr      = exmem_q.addr;
    assign Data      = exmem_q.data;
    assign MDBusy    = md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver applies directed and random
// instructions, a reference model predicts Stall and the EX/MEM contents,
// and an independent monitor compares them against the DUT.
module tb_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, NewHalt, ALUSrc;
    logic [31:0] PC2, IR2, A, B, Imm32;
    logic [3:0]  ALUOp;
    logic [2:0]  MDOp;
    logic        SysCall2, Halt2, MemToReg2, MemWrite2, MemRead2, RegWrite2, PCtoReg2;
    logic [4:0]  RW2;
    logic        SysCall3, Halt3, MemToReg3, MemWrite3, MemRead3, RegWrite3, PCtoReg3;
    logic [31:0] Addr, Data, PC3, IR3;
    logic [4:0]  RW3;
    logic        Stall, MDBusy;

    ex_stage dut (
        .clk(clk), .clear(clear), .NewHalt(NewHalt),
        .PC2(PC2), .IR2(IR2), .A(A), .B(B), .Imm32(Imm32),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MDOp(MDOp),
        .SysCall2(SysCall2), .Halt2(Halt2), .MemToReg2(MemToReg2),
        .MemWrite2(MemWrite2), .MemRead2(MemRead2), .RegWrite2(RegWrite2),
        .PCtoReg2(PCtoReg2), .RW2(RW2),
        .SysCall3(SysCall3), .Halt3(Halt3), .MemToReg3(MemToReg3),
        .MemWrite3(MemWrite3), .MemRead3(MemRead3), .RegWrite3(RegWrite3),
        .PCtoReg3(PCtoReg3),
        .Addr(Addr), .Data(Data), .PC3(PC3), .IR3(IR3), .RW3(RW3),
        .Stall(Stall), .MDBusy(MDBusy)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic [2:0]  md;
        logic        alusrc;
        logic [6:0]  ctl;
        logic [4:0]  rw;
        logic [31:0] pc, ir, a, b, imm;
    } ins_t;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [4:0]  rw;
        logic [31:0] pc, ir, addr, data;
        logic        busy;
    } out_t;

    bit   stall_q[$];
    out_t out_q[$];

    // Reference model state: HI/LO, cycles left until the unit is free,
    // the pending result, and the EX/MEM contents it expects.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_busy = 0;
    out_t        m_out = '0;

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input ins_t x);
        logic [31:0] o2;
        int unsigned sh;
        o2 = x.alusrc ? x.imm : x.b;
        sh = int'(x.ir[10:6]);
        case (x.alu)
            4'd0:  return x.a + o2;
            4'd1:  return x.a - o2;
            4'd2:  return x.a & o2;
            4'd3:  return x.a | o2;
            4'd4:  return x.a ^ o2;
            4'd5:  return ~(x.a | o2);
            4'd6:  return ($signed(x.a) < $signed(o2)) ? 32'd1 : 32'd0;
            4'd7:  return (x.a < o2) ? 32'd1 : 32'd0;
            4'd8:  return o2 << sh;
            4'd9:  return o2 >> sh;
            4'd10: return $signed(o2) >>> sh;
            4'd11: return o2 * 32'h0001_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit touches_hilo(input logic [2:0] md);
        return (md != 3'd0) && (md <= 3'd6);
    endfunction

    // One clock of stimulus: drive inputs, predict, push expectations.
    task automatic step(input ins_t x, input bit nh, input bit clr, output bit st);
        logic [63:0] prod;
        @(negedge clk);
        clear = clr; NewHalt = nh;
        PC2 = x.pc; IR2 = x.ir; A = x.a; B = x.b; Imm32 = x.imm;
        ALUSrc = x.alusrc; ALUOp = x.alu; MDOp = x.md; RW2 = x.rw;
        {SysCall2, Halt2, MemToReg2, MemWrite2, MemRead2, RegWrite2, PCtoReg2} = x.ctl;

        st = nh && touches_hilo(x.md) && (m_busy != 0);
        stall_q.push_back(st);

        if (clr) begin
            m_out = '0;
        end else if (nh) begin
            if (st) m_out = '0;
            else begin
                m_out.ctl  = x.ctl;
                m_out.rw   = x.rw;
                m_out.pc   = x.pc;
                m_out.ir   = x.ir;
                m_out.data = x.b;
                m_out.addr = (x.md == MD_MFHI) ? m_hi :
                             (x.md == MD_MFLO) ? m_lo : ref_alu(x);
            end
        end

        if (clr) begin
            m_hi = '0; m_lo = '0; m_busy = 0;
        end else if (nh) begin
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end else begin
                case (x.md)
                    MD_MULTU: begin
                        prod = {32'd0, x.a} * {32'd0, x.b};
                        {p_hi, p_lo} = prod;
                        m_busy = MD_CYCLES + 1;
                    end
                    MD_DIVU: begin
                        if (x.b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = x.a; end
                        else begin p_lo = x.a / x.b; p_hi = x.a % x.b; end
                        m_busy = MD_CYCLES + 1;
                    end
                    MD_MTHI: m_hi = x.a;
                    MD_MTLO: m_lo = x.a;
                    default: ;
                endcase
            end
        end
        m_out.busy = (m_busy != 0);
        out_q.push_back(m_out);
    endtask

    // Present an instruction until it is accepted, as the upstream would.
    task automatic issue(input ins_t x, output int nstall);
        bit st;
        nstall = 0;
        do begin
            step(x, 1'b1, 1'b0, st);
            if (st) nstall++;
        end while (st && nstall < 200);
        if (st) begin
            n_vec++; n_fail++;
            $display("FAIL issue_timeout: stalled %0d cycles, required under 200", nstall);
        end
    endtask

    function automatic ins_t mk(input logic [3:0] alu, input logic [2:0] md,
                                input logic [31:0] a, input logic [31:0] b);
        ins_t x;
        x.alu = alu; x.md = md; x.a = a; x.b = b;
        x.alusrc = 1'b0; x.imm = $urandom; x.pc = $urandom; x.ir = $urandom;
        x.rw = 5'($urandom); x.ctl = 7'($urandom);
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        int   r;
        x = mk(4'($urandom_range(0, 11)), MD_NONE, $urandom, $urandom);
        x.alusrc = 1'($urandom);
        r = $urandom_range(0, 19);
        if (r < 2)       x.md = MD_MULTU;
        else if (r < 4)  x.md = MD_DIVU;
        else if (r < 6)  x.md = MD_MFHI;
        else if (r < 8)  x.md = MD_MFLO;
        else if (r == 8) x.md = MD_MTHI;
        else if (r == 9) x.md = MD_MTLO;
        if (x.md == MD_DIVU) begin
            r = $urandom_range(0, 3);
            if (r == 0)      x.b = 32'd0;
            else if (r == 1) x.b = $urandom_range(1, 1000);
        end
        return x;
    endfunction

    // Monitor: Stall mid-cycle, registered outputs just after each edge.
    initial begin
        out_t e;
        bit   s;
        forever begin
            @(negedge clk); #1;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                chk("stall", {31'd0, Stall}, {31'd0, s});
            end
            @(posedge clk); #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("addr", Addr, e.addr);
                chk("data", Data, e.data);
                chk("pc3",  PC3,  e.pc);
                chk("ir3",  IR3,  e.ir);
                chk("rw3",  {27'd0, RW3}, {27'd0, e.rw});
                chk("ctl3", {25'd0, SysCall3, Halt3, MemToReg3, MemWrite3, MemRead3,
                             RegWrite3, PCtoReg3}, {25'd0, e.ctl});
                chk("mdbusy", {31'd0, MDBusy}, {31'd0, e.busy});
            end
        end
    end

    initial begin
        ins_t nop, x;
        bit   st;
        int   ns;
        nop = mk(4'd0, MD_NONE, 32'd0, 32'd0);
        nop.ctl = '0; nop.rw = '0; nop.pc = '0; nop.ir = '0;

        step(nop, 1'b0, 1'b1, st);
        step(nop, 1'b1, 1'b1, st);

        issue(mk(ALU_ADD, MD_NONE, 32'h7FFF_FFFF, 32'd1), ns);

        issue(mk(ALU_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'd2), ns);
        issue(mk(ALU_OR, MD_MFLO, 32'd0, 32'd0), ns);
        chk("mflo_stall_cycles", ns, 32'd33);
        issue(mk(ALU_OR, MD_MFHI, 32'd0, 32'd0), ns);

        issue(mk(ALU_ADD, MD_DIVU, 32'd100, 32'd7), ns);
        issue(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0), ns);
        issue(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0), ns);
        issue(mk(ALU_ADD, MD_DIVU, 32'd5, 32'd0), ns);
        issue(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0), ns);
        issue(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0), ns);

        issue(mk(ALU_ADD, MD_MULTU, $urandom, $urandom), ns);
        for (int i = 0; i < 10; i++) issue(mk(ALU_ADD, MD_NONE, $urandom, $urandom), ns);
        issue(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0), ns);

        issue(mk(ALU_ADD, MD_MTHI, 32'hDEAD_BEEF, 32'd0), ns);
        issue(mk(ALU_ADD, MD_MULTU, $urandom, $urandom), ns);
        for (int i = 0; i < 9; i++) issue(mk(ALU_SUB, MD_NONE, $urandom, $urandom), ns);
        step(mk(ALU_ADD, MD_NONE, $urandom, $urandom), 1'b1, 1'b1, st);
        issue(mk(ALU_ADD, MD_MFHI, 32'd0, 32'd0), ns);
        chk("post_clear_stall", ns, 32'd0);

        issue(mk(ALU_ADD, MD_MULTU, $urandom, $urandom), ns);
        for (int i = 0; i < 3; i++) issue(mk(ALU_XOR, MD_NONE, $urandom, $urandom), ns);
        for (int i = 0; i < 5; i++) step(mk(ALU_AND, MD_MFLO, $urandom, $urandom), 1'b0, 1'b0, st);
        issue(mk(ALU_ADD, MD_MFLO, 32'd0, 32'd0), ns);
        chk("frozen_stall_cycles", ns, 32'd30);

        for (int i = 0; i < 600; i++) begin
            x = rnd_ins();
            step(x, ($urandom_range(0, 9) != 0), ($urandom_range(0, 149) == 0), st);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
